sync_fifo: RTL
==============

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 8, data width in bits.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 8, pointer width; depth RAM_SIZE = 2**ADDRESS_WIDTH.
REQ-003 SHALL have parameter EDGE_MODE, default 0; 0 = level strobes, 1 = falling-edge strobes.
REQ-004 SHALL have parameter ALMOST_FULL_LEVEL, default RAM_SIZE-4, almost_full threshold.
REQ-005 SHALL have parameter ALMOST_EMPTY_LEVEL, default 4, almost_empty threshold.
REQ-006 SHALL have ports: clk  in  1  single clock, all logic rising-edge.
REQ-007 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-008 SHALL have ports: clear  in  1  synchronous flush; d  in  WORD_SIZE  write data; write  in  1  write strobe; read  in  1  read strobe; err_clr  in  1  clears error flags.
REQ-009 SHALL have ports: q  out  WORD_SIZE  head word; empty, full, almost_empty, almost_full  out  1 each; level  out  ADDRESS_WIDTH+1  occupancy; overflow, underflow  out  1 each  sticky errors.

Function
REQ-010 SHALL, in EDGE_MODE=0, treat each clock with write=1 as one write request and each clock with read=1 as one read request.
REQ-011 SHALL, in EDGE_MODE=1, register write and read each clock and raise one request on the clock where the registered value is 1 and the live value is 0.
REQ-012 SHALL present q = mem[raddr] combinationally (first-word-fall-through); q is valid whenever empty=0 and undefined-but-stable when empty=1.
REQ-013 SHALL, on an accepted write, store d at waddr and increment waddr modulo RAM_SIZE.
REQ-014 SHALL, on an accepted read, increment raddr modulo RAM_SIZE.
REQ-015 SHALL accept a write only if level<RAM_SIZE, or if level==RAM_SIZE and a read is accepted on the same clock.
REQ-016 SHALL accept a read only if level>0; a read with a write on the same clock while empty is rejected and the write accepted.
REQ-017 SHALL update level by +1 for write only, -1 for read only, and 0 for both or neither; latency from request clock to level/flag update is one clock.
REQ-018 SHALL drive empty = (level==0), full = (level==RAM_SIZE), almost_full = (level>=ALMOST_FULL_LEVEL), almost_empty = (level<=ALMOST_EMPTY_LEVEL).
REQ-019 SHALL, on clear=1, set raddr, waddr and level to 0 next clock, ignoring same-clock read/write; memory contents are not cleared.
REQ-020 SHALL have clear priority over read and write, and err_clr priority over error-flag setting.

Reset
REQ-021 SHALL, while reset_n=0, asynchronously force raddr=0, waddr=0, level=0, edge registers=0, overflow=0, underflow=0; hence empty=1, almost_empty=1, full=0, almost_full=0 (for ALMOST_FULL_LEVEL>0).
REQ-022 SHALL resume normal operation on the first rising clk after reset_n deasserts; an edge-mode strobe that is low at deassertion does not generate a request.

Configuration
REQ-023 SHALL compile the error-flag logic only when macro SYNC_FIFO_ERR_FLAGS_EN is defined: overflow sets on a rejected write and underflow on a rejected read, both held until err_clr=1 or reset.
REQ-024 SHALL, without SYNC_FIFO_ERR_FLAGS_EN, keep all ports, tie overflow and underflow to 0, and ignore err_clr.

Verification (WORD_SIZE=8, ADDRESS_WIDTH=2, EDGE_MODE=0, thresholds 3/1, macro defined)
REQ-025 SHALL cover: write 0x11,0x22,0x33,0x44 on consecutive clocks -> level 1..4, almost_full at level 3, full at 4, q=0x11 throughout.
REQ-026 SHALL cover: full, write 0x55 alone -> rejected, overflow=1, level=4; then read+write 0x55 same clock -> level stays 4, q=0x22, later reads return 0x22,0x33,0x44,0x55 (wrap-around).
REQ-027 SHALL cover: empty, read+write 0xA5 same clock -> level=1, q=0xA5, underflow=1; err_clr pulse -> underflow=0.
REQ-028 SHALL cover: level 2, clear+write on same clock -> level=0, empty=1, write discarded.
REQ-029 SHALL cover: EDGE_MODE=1, write held high 3 clocks then low -> exactly one word stored, level=1.
REQ-030 SHALL cover: reset_n pulsed low mid-write burst at level 3 -> level=0, empty=1, overflow=0 immediately, without a clock edge.

Source files
------------

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//
// Requests can be level strobes (EDGE_MODE=0, one request for every clock the
// strobe is high) or falling-edge strobes (EDGE_MODE=1, one request on the
// clock where the strobe drops). Occupancy, empty/full and almost flags come
// from a registered level counter, so they follow a request by one clock.
//
// Optional feature: define SYNC_FIFO_ERR_FLAGS_EN to build the sticky
// overflow/underflow flags. Without it both outputs are tied low and err_clr
// is ignored, but the port list is unchanged.
module sync_fifo #(
  parameter int WORD_SIZE          = 8,
  parameter int ADDRESS_WIDTH      = 8,
  parameter int EDGE_MODE          = 0,
  parameter int ALMOST_FULL_LEVEL  = (2 ** ADDRESS_WIDTH) - 4,
  parameter int ALMOST_EMPTY_LEVEL = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic [WORD_SIZE-1:0]   d,
  input  logic                   write,
  input  logic                   read,
  input  logic                   err_clr,
  output logic [WORD_SIZE-1:0]   q,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_empty,
  output logic                   almost_full,
  output logic [ADDRESS_WIDTH:0] level,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int RAM_SIZE = 2 ** ADDRESS_WIDTH;
  localparam int LVL_W    = ADDRESS_WIDTH + 1;

  // Level comparison constants, sized to the level counter.
  localparam logic [ADDRESS_WIDTH:0] LVL_FULL = LVL_W'(RAM_SIZE);
  localparam logic [ADDRESS_WIDTH:0] LVL_AF   = LVL_W'(ALMOST_FULL_LEVEL);
  localparam logic [ADDRESS_WIDTH:0] LVL_AE   = LVL_W'(ALMOST_EMPTY_LEVEL);

  // Storage and pointer state.
  logic [WORD_SIZE-1:0]   mem_q [RAM_SIZE];
  logic [ADDRESS_WIDTH-1:0] raddr_q, raddr_d;
  logic [ADDRESS_WIDTH-1:0] waddr_q, waddr_d;
  logic [ADDRESS_WIDTH:0]   level_q, level_d;

  // One-clock request pulses after strobe decoding.
  logic wr_req;
  logic rd_req;

  // Accepted requests after clear gating and occupancy checks.
  logic rd_acc;
  logic wr_acc;

  generate
    if (EDGE_MODE == 1) begin : g_edge
      logic write_q, write_d;
      logic read_q,  read_d;

      // Next value of the strobe history is simply the live strobe.
      always_comb begin
        write_d = write;
        read_d  = read;
      end

      // Strobe history; cleared by reset so a strobe that is low when reset
      // releases cannot look like a falling edge.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          write_q <= 1'b0;
          read_q  <= 1'b0;
        end else begin
          write_q <= write_d;
          read_q  <= read_d;
        end
      end

      // A request fires on the clock where the strobe goes from 1 to 0.
      assign wr_req = write_q & ~write;
      assign rd_req = read_q  & ~read;
    end else begin : g_level
      assign wr_req = write;
      assign rd_req = read;
    end
  endgenerate

  // Accept/reject decisions. A read needs data present; a write needs room,
  // or a full FIFO whose head is leaving on the same clock. Clear wins over
  // both, so nothing is accepted while flushing.
  always_comb begin
    rd_acc = 1'b0;
    wr_acc = 1'b0;
    if (!clear) begin
      rd_acc = rd_req && (level_q != '0);
      wr_acc = wr_req && ((level_q != LVL_FULL) || rd_acc);
    end
  end

  // Next pointer and occupancy values; clear resets them and drops requests.
  always_comb begin
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    level_d = level_q;
    if (clear) begin
      raddr_d = '0;
      waddr_d = '0;
      level_d = '0;
    end else begin
      if (wr_acc) waddr_d = waddr_q + 1'b1;
      if (rd_acc) raddr_d = raddr_q + 1'b1;
      if (wr_acc && !rd_acc) begin
        level_d = level_q + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        level_d = level_q - 1'b1;
      end
    end
  end

  // Pointer and occupancy registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      raddr_q <= '0;
      waddr_q <= '0;
      level_q <= '0;
    end else begin
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      level_q <= level_d;
    end
  end

  // Storage array: written on accepted writes only, never reset or flushed.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[waddr_q] <= d;
    end
  end

  // Head word falls through combinationally; stale but stable when empty.
  assign q = mem_q[raddr_q];

  // Status outputs decoded from the registered level.
  assign level        = level_q;
  assign empty        = (level_q == '0);
  assign full         = (level_q == LVL_FULL);
  assign almost_full  = (level_q >= LVL_AF);
  assign almost_empty = (level_q <= LVL_AE);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q,  overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags: set by rejected requests (not by ones dropped for a
  // clear), and err_clr overrides any set on the same clock.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if (!clear) begin
      if (wr_req && !wr_acc) overflow_d  = 1'b1;
      if (rd_req && !rd_acc) underflow_d = 1'b1;
    end
  end

  // Error flag registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule
